// File: rtl/keypad_scan_ctrl_if.sv
// Key handshake between the keypad scanner (master) and the calculator FSM (slave).
// key_held is a status line that travels with the handshake.
interface keypad_scan_ctrl_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       key_held;

  modport master (
    output key_code,
    output key_valid,
    output key_held,
    input  key_ready
  );

  modport slave (
    input  key_code,
    input  key_valid,
    input  key_held,
    output key_ready
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low keypad scanner: drives one column at a time, debounces press and release,
// and hands one 4-bit code (row*4 + col) per physical press to the consumer.
module keypad_scan_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1000,
  parameter int unsigned DB_CYCLES     = 1000000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                row_n,
  output logic [3:0]                col_n,
  keypad_scan_ctrl_if.master        key_if
);

  localparam logic [26:0] SettleLast = 27'(SETTLE_CYCLES - 1);
  localparam logic [26:0] DbLast     = 27'(DB_CYCLES - 1);

  typedef enum logic [2:0] {
    StScanDrive,
    StSample,
    StDebounce,
    StPresent,
    StWaitRelease
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sync_q, rows_s_q;
  logic [1:0]  col_idx_q, col_idx_d;
  logic [26:0] cnt_q, cnt_d;
  logic [1:0]  row_cap_q, row_cap_d;
  logic [3:0]  pat_cap_q, pat_cap_d;
  logic [3:0]  key_code_q, key_code_d;
  logic        key_valid_q, key_valid_d;
  logic        key_held_q, key_held_d;

  logic        rows_idle;
  logic        pat_stable;
  logic        settle_done;
  logic        db_done;
  logic        xfer;
  logic [1:0]  low_row;

  assign rows_idle   = (rows_s_q == 4'b1111);
  assign pat_stable  = (rows_s_q == pat_cap_q);
  assign settle_done = (cnt_q == SettleLast);
  assign db_done     = (cnt_q == DbLast);
  assign xfer        = (state_q == StPresent) && key_valid_q && key_if.key_ready;

  // Lowest-numbered low row wins when several rows are pressed on one column.
  always_comb begin
    low_row = 2'd3;
    if (!rows_s_q[0]) begin
      low_row = 2'd0;
    end else if (!rows_s_q[1]) begin
      low_row = 2'd1;
    end else if (!rows_s_q[2]) begin
      low_row = 2'd2;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StScanDrive;
      sync_q      <= 4'b1111;
      rows_s_q    <= 4'b1111;
      col_idx_q   <= 2'd0;
      cnt_q       <= '0;
      row_cap_q   <= 2'd0;
      pat_cap_q   <= 4'b1111;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync_q      <= row_n;
      rows_s_q    <= sync_q;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      row_cap_q   <= row_cap_d;
      pat_cap_q   <= pat_cap_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StScanDrive: begin
        if (settle_done) state_d = StSample;
      end
      StSample: begin
        state_d = rows_idle ? StScanDrive : StDebounce;
      end
      StDebounce: begin
        if (!pat_stable) begin
          state_d = StScanDrive;
        end else if (db_done) begin
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (xfer) state_d = StWaitRelease;
      end
      StWaitRelease: begin
        if (rows_idle && db_done) state_d = StScanDrive;
      end
      default: state_d = StScanDrive;
    endcase
  end

  // Counter, column, capture and output register updates.
  always_comb begin
    cnt_d       = cnt_q;
    col_idx_d   = col_idx_q;
    row_cap_d   = row_cap_q;
    pat_cap_d   = pat_cap_q;
    key_code_d  = key_code_q;
    key_valid_d = key_valid_q;
    key_held_d  = key_held_q;
    unique case (state_q)
      StScanDrive: begin
        cnt_d = settle_done ? '0 : cnt_q + 27'd1;
      end
      StSample: begin
        if (!rows_idle) begin
          pat_cap_d = rows_s_q;
          row_cap_d = low_row;
        end else begin
          col_idx_d = col_idx_q + 2'd1;
        end
      end
      StDebounce: begin
        if (!pat_stable) begin
          // Bounce: restart the scan from column 0.
          cnt_d     = '0;
          col_idx_d = 2'd0;
        end else if (db_done) begin
          key_code_d  = {row_cap_q, col_idx_q};
          key_valid_d = 1'b1;
          key_held_d  = 1'b1;
          cnt_d       = '0;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      StPresent: begin
        if (xfer) key_valid_d = 1'b0;
      end
      StWaitRelease: begin
        // Any low row, including a different key, restarts the release count.
        if (!rows_idle) begin
          cnt_d = '0;
        end else if (db_done) begin
          key_held_d = 1'b0;
          cnt_d      = '0;
          col_idx_d  = 2'd0;
        end else begin
          cnt_d = cnt_q + 27'd1;
        end
      end
      default: ;
    endcase
  end

  assign col_n            = ~(4'b0001 << col_idx_q);
  assign key_if.key_code  = key_code_q;
  assign key_if.key_valid = key_valid_q;
  assign key_if.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: a keypad matrix model driven by directed presses, with a
// scoreboard queue of expected codes popped by a monitor on every handshake transfer.
module tb_keypad_scan_ctrl;
  localparam int unsigned Settle = 4;
  localparam int unsigned Db     = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] press = '0;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  exp_q[$];

  keypad_scan_ctrl_if kif ();

  keypad_scan_ctrl #(
    .SETTLE_CYCLES(Settle),
    .DB_CYCLES    (Db)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .row_n (row_n),
    .col_n (col_n),
    .key_if(kif)
  );

  always #5 clk = ~clk;

  // Matrix model: a pressed key (r,c) pulls row r low while column c is driven low.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        if (press[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Scoreboard monitor: every transfer must match the oldest expected code.
  initial begin
    logic [3:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && kif.key_valid && kif.key_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key: got %0h, expected no transfer at %0t",
                   kif.key_code, $time);
        end else begin
          e = exp_q.pop_front();
          check("key_code", {28'b0, kif.key_code}, {28'b0, e});
        end
      end
    end
  end

  // Assert rst for one edge, then check reset outputs; pending expectations are discarded.
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    check("rst_valid", {31'b0, kif.key_valid}, 32'd0);
    check("rst_held", {31'b0, kif.key_held}, 32'd0);
    check("rst_col", {28'b0, col_n}, 32'he);
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!kif.key_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!kif.key_valid) timeout(name);
  endtask

  task automatic wait_held_low(input string name);
    int n = 0;
    while (kif.key_held && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (kif.key_held) timeout(name);
  endtask

  initial begin
    logic [3:0] ec;
    int n;
    kif.key_ready = 1'b1;
    do_reset();

    // 1: idle scan, each column held Settle+1 cycles.
    for (int k = 0; k < 40; k++) begin
      ec = ~(4'b0001 << ((k / 5) % 4));
      check("s1_col", {28'b0, col_n}, {28'b0, ec});
      check("s1_valid", {31'b0, kif.key_valid}, 32'd0);
      @(negedge clk);
    end

    // 2: steady press row2/col1, consumer always ready.
    press[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid("s2_wait_valid");
    check("s2_held", {31'b0, kif.key_held}, 32'd1);
    @(negedge clk);
    check("s2_valid_one_cycle", {31'b0, kif.key_valid}, 32'd0);
    press[9] = 1'b0;
    repeat (9) @(negedge clk);
    check("s2_held_before", {31'b0, kif.key_held}, 32'd1);
    @(negedge clk);
    check("s2_held_fall", {31'b0, kif.key_held}, 32'd0);
    check("s2_col_restart", {28'b0, col_n}, 32'he);

    // 3: 3-cycle glitch on row0 while column 3 is driven.
    n = 0;
    while (col_n != 4'b0111 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (col_n != 4'b0111) timeout("s3_wait_col3");
    press[3] = 1'b1;
    repeat (3) @(negedge clk);
    press[3] = 1'b0;
    repeat (2) @(negedge clk);
    check("s3_col_held", {28'b0, col_n}, 32'h7);
    @(negedge clk);
    check("s3_col_restart", {28'b0, col_n}, 32'he);
    check("s3_held", {31'b0, kif.key_held}, 32'd0);
    for (int k = 0; k < 30; k++) begin
      check("s3_no_valid", {31'b0, kif.key_valid}, 32'd0);
      @(negedge clk);
    end

    // 4: backpressure with release while the code is pending.
    kif.key_ready = 1'b0;
    press[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid("s4_wait_valid");
    for (int k = 0; k < 30; k++) begin
      check("s4_valid_hold", {31'b0, kif.key_valid}, 32'd1);
      check("s4_code_hold", {28'b0, kif.key_code}, 32'd9);
      if (k == 15) press[9] = 1'b0;
      @(negedge clk);
    end
    kif.key_ready = 1'b1;
    @(negedge clk);
    check("s4_valid_drop", {31'b0, kif.key_valid}, 32'd0);
    check("s4_held", {31'b0, kif.key_held}, 32'd1);
    repeat (7) @(negedge clk);
    check("s4_held_before", {31'b0, kif.key_held}, 32'd1);
    @(negedge clk);
    check("s4_held_fall", {31'b0, kif.key_held}, 32'd0);

    // 5: rows 1 and 3 on column 2 -> lowest row wins.
    press[6]  = 1'b1;
    press[14] = 1'b1;
    exp_q.push_back(4'd6);
    wait_valid("s5_wait_valid");
    check("s5_held", {31'b0, kif.key_held}, 32'd1);
    @(negedge clk);
    press[6]  = 1'b0;
    press[14] = 1'b0;
    wait_held_low("s5_release");

    // 6: reset while a code is pending, then re-detect the still-held key once.
    kif.key_ready = 1'b0;
    press[9] = 1'b1;
    exp_q.push_back(4'd9);
    wait_valid("s6_wait_valid");
    check("s6_pending_code", {28'b0, kif.key_code}, 32'd9);
    @(negedge clk);
    do_reset();
    exp_q.push_back(4'd9);
    kif.key_ready = 1'b1;
    wait_valid("s6_redetect");
    repeat (60) @(negedge clk);
    check("s6_held_while_pressed", {31'b0, kif.key_held}, 32'd1);
    press[9] = 1'b0;
    wait_held_low("s6_release");
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scans a 4x4 active-low keypad matrix for the calculator front end. It drives one column at a time, debounces the detected press in time, and delivers a 4-bit key code over a valid/ready handshake to the calculator FSM. It also debounces key release and does not resume scanning until the key is released, so each press yields exactly one code.

Parameters:
SETTLE_CYCLES, 1000, cycles a column is driven before rows are sampled; legal range 3 to 2^27-1.
DB_CYCLES, 1000000, cycles a press or release must stay stable to be accepted; legal range 2 to 2^27-1.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
row_n  in  4  keypad rows, active-low, externally pulled up, asynchronous to clk
col_n  out  4  column drives, active-low, exactly one bit low at any time
key_code  out  4  encoded key, row*4 + col
key_valid  out  1  key_code is valid
key_ready  in  1  consumer accepts key_code
key_held  out  1  a debounced key is currently held or has not yet been released

Behaviour:
- Clock and reset: reset rst, synchronous, active-high; clock clk. All state updates occur on the posedge of clk.
- Input synchroniser: row_n passes through a 2-flop synchroniser (rows_s). All decisions use rows_s, so row changes are seen 2 cycles late.
- Internal state: column index col_idx[1:0], 27-bit cycle counter cnt, captured row index row_cap[1:0], captured row pattern pat_cap[3:0].
- Reset values: state SCAN_DRIVE, col_idx=0, cnt=0, col_n=4'b1110, key_code=0, key_valid=0, key_held=0, synchroniser flops=4'b1111.
- col_n = ~(4'b0001 << col_idx) in every state. The column is held, not scanned, during DEBOUNCE, PRESENT and WAIT_RELEASE.
- SCAN_DRIVE: cnt increments each cycle. When cnt==SETTLE_CYCLES-1, set cnt to 0 and go to SAMPLE. The state lasts exactly SETTLE_CYCLES cycles.
- SAMPLE (1 cycle):
  - If rows_s != 4'b1111: capture pat_cap=rows_s and row_cap=lowest index of a low bit (lowest row wins), then go to DEBOUNCE.
  - Otherwise: col_idx++ (3 wraps to 0), then go to SCAN_DRIVE.
  - Per-column idle period is therefore SETTLE_CYCLES+1 cycles.
- DEBOUNCE: cnt increments each cycle.
  - If rows_s != pat_cap in any cycle: set cnt to 0, set col_idx to 0 and go to SCAN_DRIVE (bounce rejected).
  - When cnt==DB_CYCLES-1 with the pattern stable: set key_code={row_cap,col_idx}, key_valid=1, key_held=1, set cnt to 0 and go to PRESENT.
- PRESENT:
  - key_valid and key_code are held stable until key_valid && key_ready, regardless of physical release.
  - On the transfer cycle, key_valid goes to 0 on the next edge and the state goes to WAIT_RELEASE.
  - key_ready is ignored outside PRESENT.
- WAIT_RELEASE: key_held stays 1.
  - Any rows_s bit low sets cnt to 0.
  - When rows_s==4'b1111 and cnt==DB_CYCLES-1: key_held=0, cnt=0, col_idx=0 and go to SCAN_DRIVE.
  - A press of another key during this state is ignored; its bounce only restarts the release count.
- Width rules: cnt is 27 bits. Comparisons use the parameter minus 1. Parameters outside their legal range are unsupported.
- Reset mid-operation: rst in any state returns all outputs to reset values on the next edge. A pending key is discarded.
- key_valid never asserts for the same physical press twice.

Test Plan:
Use SETTLE_CYCLES=4 and DB_CYCLES=8 for all scenarios.
1. No keys, 40 cycles after reset -> col_n sequence 1110,1101,1011,0111,1110, each held 5 cycles; key_valid stays 0.
2. Press row2/col1 steadily, key_ready=1 -> one-cycle key_valid with key_code=9, key_held=1. Release -> key_held=0 exactly 8 cycles after rows_s returns to 1111, and scanning restarts at col_n=1110.
3. Row0 low on col3 for 3 cycles, then high -> no key_valid; scanning resumes at col_n=1110 and key_held stays 0.
4. Press row2/col1 with key_ready=0 for 30 cycles, releasing the key midway -> key_valid=1 with key_code=9 stable throughout. Raise key_ready -> one transfer, then key_held falls after 8 release cycles.
5. Rows 1 and 3 pressed together on col2 -> key_code=6 (lowest row wins).
6. Assert rst for 1 cycle while in PRESENT -> next cycle key_valid=0, key_held=0, col_n=1110. After reset, with the key still held, the key is re-detected and reported exactly once.
